// File: rtl/tcdm_error_responder.sv
// tcdm_error_responder
// Terminates TCDM requests that hit unmapped space. Every request on every
// channel is granted in the same cycle. A fixed error response is returned
// LATENCY cycles later. Optionally, the first offending access is logged and
// all offending accesses are counted.
//
// Build option: define TCDM_ERROR_LOG_EN to include the error log FSM,
// the saturating error counter and irq_o. Without it, err_* outputs,
// err_cnt_o and irq_o are tied to 0 and err_clear_i is ignored.
//
// Handshake: gnt_o[i] follows req_i[i] combinationally, so there is no
// backpressure. Each granted cycle produces exactly one r_valid_o[i] pulse
// LATENCY cycles later. r_rdata_o[i] and r_opc_o[i] are only meaningful
// while r_valid_o[i] is 1. Otherwise r_rdata_o[i] is held at 0.
module tcdm_error_responder #(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [31:0] ERROR_RESPONSE = 32'hBADACCE5,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned WRITE_OPC      = 1,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [N_CH-1:0]                      req_i,
  input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      add_i,
  input  logic [N_CH-1:0]                      wen_i,
  output logic [N_CH-1:0]                      gnt_o,
  output logic [N_CH-1:0]                      r_valid_o,
  output logic [N_CH-1:0]                      r_opc_o,
  output logic [N_CH-1:0][DATA_WIDTH-1:0]      r_rdata_o,
  input  logic                                 err_clear_i,
  output logic                                 err_valid_o,
  output logic [ADDR_WIDTH-1:0]                err_addr_o,
  output logic [CH_W-1:0]                      err_ch_o,
  output logic                                 err_rd_o,
  output logic                                 err_ovf_o,
  output logic [CNT_WIDTH-1:0]                 err_cnt_o,
  output logic                                 irq_o
);

  // The response word is zero-extended or truncated to the data width.
  localparam logic [DATA_WIDTH-1:0] RESP = DATA_WIDTH'(ERROR_RESPONSE);
  localparam logic WR_OPC = (WRITE_OPC != 0);

  // Per-channel delay lines. Bit 0 is the newest entry.
  // Bit LATENCY-1 is the response presented this cycle.
  logic [N_CH-1:0][LATENCY-1:0] vld_q, vld_d;
  logic [N_CH-1:0][LATENCY-1:0] opc_q, opc_d;

  assign gnt_o = req_i;

  // Shift each channel's delay line. The oldest entry falls off the top
  // when the wider concatenation is truncated.
  always_comb begin
    vld_d = vld_q;
    opc_d = opc_q;
    for (int i = 0; i < N_CH; i++) begin
      vld_d[i] = LATENCY'({vld_q[i], req_i[i]});
      opc_d[i] = LATENCY'({opc_q[i], req_i[i] & (wen_i[i] | WR_OPC)});
    end
  end

  // Response pipeline registers. Reset discards anything in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      opc_q <= '0;
    end else begin
      vld_q <= vld_d;
      opc_q <= opc_d;
    end
  end

  // Present the oldest pipeline entry. Read data is zero unless valid.
  always_comb begin
    r_valid_o = '0;
    r_opc_o   = '0;
    r_rdata_o = '0;
    for (int i = 0; i < N_CH; i++) begin
      r_valid_o[i] = vld_q[i][LATENCY-1];
      r_opc_o[i]   = opc_q[i][LATENCY-1];
      r_rdata_o[i] = vld_q[i][LATENCY-1] ? RESP : '0;
    end
  end

`ifdef TCDM_ERROR_LOG_EN

  typedef enum logic {
    IDLE   = 1'b0,
    LOGGED = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic                   rd_q, rd_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [3:0]             pop;
  logic [CNT_WIDTH+3:0]   sum;

  // Next log state. A clear is applied first, so any request in the same
  // cycle is logged as if it arrived in a freshly cleared log.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_CH; i++) begin
      pop = pop + 4'(req_i[i]);
    end

    state_d = err_clear_i ? IDLE : state_q;
    addr_d  = err_clear_i ? '0   : addr_q;
    ch_d    = err_clear_i ? '0   : ch_q;
    rd_d    = err_clear_i ? 1'b0 : rd_q;
    ovf_d   = err_clear_i ? 1'b0 : ovf_q;
    sum     = {4'b0, (err_clear_i ? {CNT_WIDTH{1'b0}} : cnt_q)}
              + {{CNT_WIDTH{1'b0}}, pop};

    if (|req_i) begin
      if (state_d == IDLE) begin
        state_d = LOGGED;
        ovf_d   = (pop > 4'd1);
        // Scan downward so that the lowest requesting channel wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
          if (req_i[i]) begin
            addr_d = add_i[i];
            ch_d   = CH_W'(i);
            rd_d   = wen_i[i];
          end
        end
      end else begin
        ovf_d = 1'b1;
      end
    end

    cnt_d = (sum > {4'b0, CNT_MAX}) ? CNT_MAX : sum[CNT_WIDTH-1:0];
  end

  // Log and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ch_q    <= '0;
      rd_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ch_q    <= ch_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign err_valid_o = (state_q == LOGGED);
  assign irq_o       = (state_q == LOGGED);
  assign err_addr_o  = addr_q;
  assign err_ch_o    = ch_q;
  assign err_rd_o    = rd_q;
  assign err_ovf_o   = ovf_q;
  assign err_cnt_o   = cnt_q;

`else

  // The log is not built. The inputs it would consume are deliberately unused.
  logic unused_log_inputs;
  assign unused_log_inputs = ^{err_clear_i, add_i};

  assign err_valid_o = 1'b0;
  assign irq_o       = 1'b0;
  assign err_addr_o  = '0;
  assign err_ch_o    = '0;
  assign err_rd_o    = 1'b0;
  assign err_ovf_o   = 1'b0;
  assign err_cnt_o   = '0;

`endif

endmodule

// File: tb/tb_tcdm_error_responder.sv
// Directed bench for tcdm_error_responder. Four instances cover the
// parameter sets of interest:
//   a: defaults (LATENCY=1, WRITE_OPC=1)
//   b: LATENCY=3
//   c: WRITE_OPC=0
//   d: CNT_WIDTH=2, LATENCY=2
// Log expectations collapse to 0 when TCDM_ERROR_LOG_EN is not defined.
module tb_tcdm_error_responder;

`ifdef TCDM_ERROR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  localparam logic [31:0] RESP = 32'hBADACCE5;

  logic clk;
  logic rst;
  logic rst_d;
  int   vectors;
  int   miscompares;

  // Instance a
  logic [1:0] req_a, wen_a, gnt_a, rv_a, ro_a;
  logic [1:0][31:0] add_a, rd_a;
  logic clr_a, ev_a, erd_a, eovf_a, irq_a;
  logic [31:0] eaddr_a;
  logic [0:0] ech_a;
  logic [15:0] ecnt_a;

  // Instance b
  logic [1:0] req_b, wen_b, gnt_b, rv_b, ro_b;
  logic [1:0][31:0] add_b, rd_b;
  logic clr_b, ev_b, erd_b, eovf_b, irq_b;
  logic [31:0] eaddr_b;
  logic [0:0] ech_b;
  logic [15:0] ecnt_b;

  // Instance c
  logic [1:0] req_c, wen_c, gnt_c, rv_c, ro_c;
  logic [1:0][31:0] add_c, rd_c;
  logic clr_c, ev_c, erd_c, eovf_c, irq_c;
  logic [31:0] eaddr_c;
  logic [0:0] ech_c;
  logic [15:0] ecnt_c;

  // Instance d
  logic [1:0] req_d, wen_d, gnt_d, rv_d, ro_d;
  logic [1:0][31:0] add_d, rd_d;
  logic clr_d, ev_d, erd_d, eovf_d, irq_d;
  logic [31:0] eaddr_d;
  logic [0:0] ech_d;
  logic [1:0] ecnt_d;

  tcdm_error_responder dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .add_i(add_a), .wen_i(wen_a),
    .gnt_o(gnt_a), .r_valid_o(rv_a), .r_opc_o(ro_a), .r_rdata_o(rd_a),
    .err_clear_i(clr_a), .err_valid_o(ev_a), .err_addr_o(eaddr_a),
    .err_ch_o(ech_a), .err_rd_o(erd_a), .err_ovf_o(eovf_a),
    .err_cnt_o(ecnt_a), .irq_o(irq_a)
  );

  tcdm_error_responder #(.LATENCY(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .add_i(add_b), .wen_i(wen_b),
    .gnt_o(gnt_b), .r_valid_o(rv_b), .r_opc_o(ro_b), .r_rdata_o(rd_b),
    .err_clear_i(clr_b), .err_valid_o(ev_b), .err_addr_o(eaddr_b),
    .err_ch_o(ech_b), .err_rd_o(erd_b), .err_ovf_o(eovf_b),
    .err_cnt_o(ecnt_b), .irq_o(irq_b)
  );

  tcdm_error_responder #(.WRITE_OPC(0)) dut_c (
    .clk_i(clk), .rst_i(rst), .req_i(req_c), .add_i(add_c), .wen_i(wen_c),
    .gnt_o(gnt_c), .r_valid_o(rv_c), .r_opc_o(ro_c), .r_rdata_o(rd_c),
    .err_clear_i(clr_c), .err_valid_o(ev_c), .err_addr_o(eaddr_c),
    .err_ch_o(ech_c), .err_rd_o(erd_c), .err_ovf_o(eovf_c),
    .err_cnt_o(ecnt_c), .irq_o(irq_c)
  );

  tcdm_error_responder #(.CNT_WIDTH(2), .LATENCY(2)) dut_d (
    .clk_i(clk), .rst_i(rst_d), .req_i(req_d), .add_i(add_d), .wen_i(wen_d),
    .gnt_o(gnt_d), .r_valid_o(rv_d), .r_opc_o(ro_d), .r_rdata_o(rd_d),
    .err_clear_i(clr_d), .err_valid_o(ev_d), .err_addr_o(eaddr_d),
    .err_ch_o(ech_d), .err_rd_o(erd_d), .err_ovf_o(eovf_d),
    .err_cnt_o(ecnt_d), .irq_o(irq_d)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Log-dependent expectation
  function automatic logic [63:0] lg(input logic [63:0] v);
    return LOG_EN ? v : 64'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled at the falling edge. Inputs are then driven for the next rising edge.
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; rst_d = 1'b1;
    req_a = '0; wen_a = '0; add_a = '0; clr_a = 1'b0;
    req_b = '0; wen_b = '0; add_b = '0; clr_b = 1'b0;
    req_c = '0; wen_c = '0; add_c = '0; clr_c = 1'b0;
    req_d = '0; wen_d = '0; add_d = '0; clr_d = 1'b0;
    tick(); tick();

    // Values held while reset is asserted
    chk("rst_gnt",   64'(gnt_a),  64'd0);
    chk("rst_rvalid",64'(rv_a),   64'd0);
    chk("rst_rdata", 64'(rd_a),   64'd0);
    chk("rst_evalid",64'(ev_a),   64'd0);
    chk("rst_cnt",   64'(ecnt_a), 64'd0);
    chk("rst_irq",   64'(irq_a),  64'd0);
    rst = 1'b0; rst_d = 1'b0;
    tick();

    // Single read on ch0 (LATENCY=1)
    req_a = 2'b01; wen_a = 2'b01; add_a[0] = 32'h1A000010;
    #1 chk("s1_gnt", 64'(gnt_a), 64'h1);
    tick();
    chk("s1_rvalid", 64'(rv_a),     64'h1);
    chk("s1_ropc",   64'(ro_a),     64'h1);
    chk("s1_rdata0", 64'(rd_a[0]),  64'(RESP));
    chk("s1_rdata1", 64'(rd_a[1]),  64'd0);
    chk("s1_evalid", 64'(ev_a),     lg(1));
    chk("s1_eaddr",  64'(eaddr_a),  lg(64'h1A000010));
    chk("s1_ech",    64'(ech_a),    64'd0);
    chk("s1_erd",    64'(erd_a),    lg(1));
    chk("s1_irq",    64'(irq_a),    lg(1));
    chk("s1_cnt",    64'(ecnt_a),   lg(1));
    chk("s1_ovf",    64'(eovf_a),   64'd0);
    req_a = 2'b00;
    tick();
    chk("s1_rvalid_off", 64'(rv_a),    64'd0);
    chk("s1_rdata_off",  64'(rd_a[0]), 64'd0);

    // Clear the log back to IDLE
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    chk("clr_evalid", 64'(ev_a),   64'd0);
    chk("clr_cnt",    64'(ecnt_a), 64'd0);
    chk("clr_irq",    64'(irq_a),  64'd0);

    // Two channels request together from IDLE
    req_a = 2'b11; wen_a = 2'b01; add_a[0] = 32'h100; add_a[1] = 32'h200;
    #1 chk("s4_gnt", 64'(gnt_a), 64'h3);
    tick();
    chk("s4_ech",    64'(ech_a),   64'd0);
    chk("s4_ovf",    64'(eovf_a),  lg(1));
    chk("s4_cnt",    64'(ecnt_a),  lg(2));
    chk("s4_eaddr",  64'(eaddr_a), lg(64'h100));
    chk("s4_erd",    64'(erd_a),   lg(1));
    chk("s4_rvalid", 64'(rv_a),    64'h3);
    chk("s4_ropc",   64'(ro_a),    64'h3);
    chk("s4_rdata1", 64'(rd_a[1]), 64'(RESP));

    // Clear coincides with a ch1 write while LOGGED
    req_a = 2'b10; wen_a = 2'b00; add_a[1] = 32'h0000_0040; clr_a = 1'b1;
    tick();
    clr_a = 1'b0; req_a = 2'b00;
    chk("s5_evalid", 64'(ev_a),    lg(1));
    chk("s5_eaddr",  64'(eaddr_a), lg(64'h40));
    chk("s5_ech",    64'(ech_a),   lg(1));
    chk("s5_ovf",    64'(eovf_a),  64'd0);
    chk("s5_cnt",    64'(ecnt_a),  lg(1));
    chk("s5_erd",    64'(erd_a),   64'd0);
    chk("s5_rvalid", 64'(rv_a),    64'h2);
    chk("s5_ropc",   64'(ro_a),    64'h2);

    // A further request while LOGGED sets overflow and keeps the capture
    req_a = 2'b01; wen_a = 2'b01; add_a[0] = 32'h999;
    tick();
    req_a = 2'b00;
    chk("lg_ovf",   64'(eovf_a),  lg(1));
    chk("lg_cnt",   64'(ecnt_a),  lg(2));
    chk("lg_eaddr", 64'(eaddr_a), lg(64'h40));

    // LATENCY=3: ch1 requests on ticks 0..3, responses on ticks 3..6
    wen_b = 2'b10; add_b[1] = 32'h2000;
    for (int t = 0; t < 9; t++) begin
      chk($sformatf("s2_rvalid_t%0d", t), 64'(rv_b),
          (t >= 3 && t <= 6) ? 64'h2 : 64'h0);
      if (t == 3) chk("s2_rdata1", 64'(rd_b[1]), 64'(RESP));
      req_b = (t < 4) ? 2'b10 : 2'b00;
      tick();
    end
    chk("s2_cnt", 64'(ecnt_b), lg(4));
    chk("s2_ovf", 64'(eovf_b), lg(1));
    chk("s2_ech", 64'(ech_b),  lg(1));

    // WRITE_OPC=0: write is acknowledged without opcode error, read still flags it
    req_c = 2'b10; wen_c = 2'b00; add_c[1] = 32'h55;
    tick();
    chk("s3_rvalid", 64'(rv_c),    64'h2);
    chk("s3_ropc",   64'(ro_c),    64'h0);
    chk("s3_rdata1", 64'(rd_c[1]), 64'(RESP));
    chk("s3_erd",    64'(erd_c),   64'd0);
    chk("s3_ech",    64'(ech_c),   lg(1));
    req_c = 2'b01; wen_c = 2'b01;
    tick();
    req_c = 2'b00;
    chk("s3_rd_ropc", 64'(ro_c), 64'h1);

    // CNT_WIDTH=2: five requests saturate the counter at 3
    req_d = 2'b01; wen_d = 2'b01; add_d[0] = 32'h77;
    tick(); tick();
    chk("s6_cnt2", 64'(ecnt_d), lg(2));
    tick();
    chk("s6_cnt3", 64'(ecnt_d), lg(3));
    tick();
    chk("s6_cnt_sat4", 64'(ecnt_d), lg(3));
    tick();
    chk("s6_cnt_sat5", 64'(ecnt_d), lg(3));
    chk("s6_ovf",      64'(eovf_d), lg(1));
    chk("s6_rvalid",   64'(rv_d),   64'h1);
    // Reset while the last response is still in flight
    req_d = 2'b00; rst_d = 1'b1;
    #1;
    chk("s6_rst_rvalid", 64'(rv_d),    64'd0);
    chk("s6_rst_rdata",  64'(rd_d[0]), 64'd0);
    chk("s6_rst_evalid", 64'(ev_d),    64'd0);
    chk("s6_rst_cnt",    64'(ecnt_d),  64'd0);
    chk("s6_rst_ovf",    64'(eovf_d),  64'd0);
    chk("s6_rst_eaddr",  64'(eaddr_d), 64'd0);
    chk("s6_rst_irq",    64'(irq_d),   64'd0);
    tick();
    rst_d = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("s6_post_rvalid_t%0d", t), 64'(rv_d), 64'd0);
    end
    chk("s6_post_evalid", 64'(ev_d),   64'd0);
    chk("s6_post_cnt",    64'(ecnt_d), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tcdm_error_responder.md
TCDM_ERROR_RESPONDER -- requirements
Module: tcdm_error_responder

Interface
REQ-001 SHALL have parameter N_CH, default 2, meaning number of independent TCDM slave channels (1..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning request address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning read data width.
REQ-004 SHALL have parameter ERROR_RESPONSE, default 32'hBADACCE5, meaning read data returned, zero-extended or truncated to DATA_WIDTH.
REQ-005 SHALL have parameter LATENCY, default 1, meaning cycles from grant to response (1..4).
REQ-006 SHALL have parameter WRITE_OPC, default 1, meaning writes also flag r_opc when 1 and are silently acknowledged when 0.
REQ-007 SHALL have parameter CNT_WIDTH, default 16, meaning error counter width.
REQ-008 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-009 SHALL have port rst_i, input, 1, meaning asynchronous active-high reset.
REQ-010 SHALL have port req_i, input, N_CH, meaning per-channel request.
REQ-011 SHALL have port add_i, input, N_CH x ADDR_WIDTH, meaning per-channel address.
REQ-012 SHALL have port wen_i, input, N_CH, meaning per-channel direction (1 = read, 0 = write).
REQ-013 SHALL have port gnt_o, output, N_CH, meaning per-channel grant.
REQ-014 SHALL have ports r_valid_o, output, N_CH; r_opc_o, output, N_CH; and r_rdata_o, output, N_CH x DATA_WIDTH, meaning the per-channel response.
REQ-015 SHALL have port err_clear_i, input, 1, meaning single-cycle clear of the error log and counter.
REQ-016 SHALL have ports err_valid_o, 1; err_addr_o, ADDR_WIDTH; err_ch_o, clog2(N_CH) (minimum 1); err_rd_o, 1; and err_ovf_o, 1, all outputs, meaning the first-error record.
REQ-017 SHALL have ports err_cnt_o, output, CNT_WIDTH, and irq_o, output, 1.

Function
REQ-018 SHALL drive gnt_o[i] = req_i[i] combinationally; no backpressure.
REQ-019 SHALL assert r_valid_o[i] for exactly one cycle, exactly LATENCY cycles after each granted cycle on channel i; back-to-back requests SHALL yield back-to-back responses.
REQ-020 SHALL drive r_rdata_o[i] = ERROR_RESPONSE while r_valid_o[i] = 1 and 0 otherwise, for reads and writes alike.
REQ-021 SHALL assert r_opc_o[i] with r_valid_o[i] for reads; for writes only when WRITE_OPC = 1.
REQ-022 SHALL never modify state on writes other than the log and counter.
REQ-023 SHALL implement the log FSM with states IDLE and LOGGED: IDLE to LOGGED on any req_i bit; LOGGED to IDLE on err_clear_i.
REQ-024 On an IDLE to LOGGED transition, SHALL capture the address, index and wen of the lowest-indexed requesting channel.
REQ-025 SHALL set err_ovf_o when any further request is granted while LOGGED, or when more than one channel requests in the capturing cycle.
REQ-026 SHALL assert err_valid_o only in LOGGED; irq_o = err_valid_o.
REQ-027 SHALL increment err_cnt_o each cycle by the popcount of req_i, saturating at 2^CNT_WIDTH-1.
REQ-028 When err_clear_i coincides with requests, SHALL clear then apply the same cycle: FSM ends LOGGED with the new capture, err_ovf_o = multi-request rule only, err_cnt_o = that cycle's popcount.
REQ-029 SHALL record errors only from req_i, independent of response pipeline state.

Reset
REQ-030 SHALL, while rst_i = 1, asynchronously force all outputs except gnt_o to 0, clear the response pipeline, set the FSM to IDLE and zero the counter.
REQ-031 SHALL discard any responses in flight when reset is asserted mid-operation; none SHALL emerge after release.

Configuration
REQ-032 With TCDM_ERROR_LOG_EN defined, SHALL include the log FSM, counter and irq as specified.
REQ-033 Without TCDM_ERROR_LOG_EN, SHALL remove the log and counter and tie err_* outputs, err_cnt_o and irq_o to 0, leaving response behaviour unchanged; err_clear_i is ignored.

Verification
REQ-034 Scenario 1: N_CH=2, LATENCY=1, read on ch0 at add 0x1A000010 -> gnt same cycle; next cycle r_valid=1, r_opc=1, r_rdata=0xBADACCE5; err_addr=0x1A000010, err_ch=0, err_rd=1, irq=1.
REQ-035 Scenario 2: LATENCY=3, ch1 requests 4 consecutive cycles -> r_valid high on cycles 3..6, err_cnt=4, err_ovf=1.
REQ-036 Scenario 3: WRITE_OPC=0, write on ch1 -> r_valid=1, r_opc=0, r_rdata=0xBADACCE5 one cycle later; err_rd=0.
REQ-037 Scenario 4: ch0 and ch1 request in the same cycle from IDLE -> err_ch=0, err_ovf=1, err_cnt=2.
REQ-038 Scenario 5: LOGGED, err_clear_i with ch1 write at 0x0000_0040 -> next cycle err_valid=1, err_addr=0x40, err_ch=1, err_ovf=0, err_cnt=1.
REQ-039 Scenario 6: CNT_WIDTH=2, 5 requests, then rst_i pulsed with LATENCY=2 response in flight -> err_cnt saturates at 3; after reset no r_valid, all log outputs 0.
